// File: rtl/config_reg_pkg.sv
// config_reg_pkg: shared types and constants for the configuration register bank.
// Provides the register address enum, per-register reset values and a lookup helper.
package config_reg_pkg;

   localparam int NUM_REGS = 8;
   localparam int DATA_W   = 16;

   typedef enum logic [2:0] {
      adc0_reg         = 3'd0,
      adc1_reg         = 3'd1,
      temp_sensor0_reg = 3'd2,
      temp_sensor1_reg = 3'd3,
      analog_test      = 3'd4,
      digital_test     = 3'd5,
      amp_gain         = 3'd6,
      digital_config   = 3'd7
   } address_t;

   localparam logic [15:0] ADC0_RST         = 16'hFFFF;
   localparam logic [15:0] ADC1_RST         = 16'h0000;
   localparam logic [15:0] TEMP_SENSOR0_RST = 16'h0000;
   localparam logic [15:0] TEMP_SENSOR1_RST = 16'h0000;
   localparam logic [15:0] ANALOG_TEST_RST  = 16'hABCD;
   localparam logic [15:0] DIGITAL_TEST_RST = 16'h0000;
   localparam logic [15:0] AMP_GAIN_RST     = 16'h0000;
   localparam logic [15:0] DIGITAL_CFG_RST  = 16'h0001;

   // Constant function so generate loops can pick each cell's reset value.
   function automatic logic [15:0] reset_value(int idx);
      logic [15:0] v;
      v = 16'h0000;
      case (idx)
         0:       v = ADC0_RST;
         1:       v = ADC1_RST;
         2:       v = TEMP_SENSOR0_RST;
         3:       v = TEMP_SENSOR1_RST;
         4:       v = ANALOG_TEST_RST;
         5:       v = DIGITAL_TEST_RST;
         6:       v = AMP_GAIN_RST;
         7:       v = DIGITAL_CFG_RST;
         default: v = 16'h0000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/config_reg_if.sv
// config_reg_if: host-side register access bus.
// write/data_in/address driven by master; data_out returned by slave.
interface config_reg_if;
   import config_reg_pkg::*;

   logic        write;
   logic [15:0] data_in;
   address_t    address;
   logic [15:0] data_out;

   modport master (
      output write,
      output data_in,
      output address,
      input  data_out
   );

   modport slave (
      input  write,
      input  data_in,
      input  address,
      output data_out
   );

endinterface

// File: rtl/config_reg_cell.sv
// config_reg_cell: one 16-bit register, sync active-high reset to RESET_VAL.
// Ports: clk_i, rst_i, en_i (load), d_i (load data), q_o (stored value).
module config_reg_cell #(
   parameter logic [15:0] RESET_VAL = 16'h0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [15:0] d_i,
   output logic [15:0] q_o
);

   logic [15:0] data_q;
   logic [15:0] data_d;

   always_comb begin
      data_d = data_q;
      if (en_i) begin
         data_d = d_i;
      end
   end

   // Reset takes priority over a concurrent load.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= RESET_VAL;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/config_reg.sv
// config_reg: bank of eight 16-bit config/status registers.
// Ports: clk, reset (sync, active-high), bus (slave: write/data_in/address in, data_out out).
module config_reg
   import config_reg_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   config_reg_if.slave  bus
);

   logic [15:0] cell_q [NUM_REGS];

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
      logic en;

      assign en = bus.write && (bus.address == address_t'(i));

      config_reg_cell #(
         .RESET_VAL (reset_value(i))
      ) u_cell (
         .clk_i (clk),
         .rst_i (reset),
         .en_i  (en),
         .d_i   (bus.data_in),
         .q_o   (cell_q[i])
      );
   end

   // Combinational read: shows pre-edge contents during a write.
   always_comb begin
      bus.data_out = cell_q[bus.address];
   end

endmodule

// File: tb/tb_config_reg.sv
// tb_config_reg: randomized scoreboard bench for config_reg.
// Stimulus pushes expected reads from an array model; a monitor pops and compares.
module tb_config_reg;
   import config_reg_pkg::*;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] exp;
      string       tag;
   } exp_t;

   logic clk;
   logic reset;
   config_reg_if bus ();

   config_reg dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   exp_t        sb_q[$];
   logic        chk_en;
   logic [15:0] model [8];
   logic [15:0] rst_tab [8];
   string       cur_tag;

   // Drive one cycle at negedge. If chk, the value data_out must show
   // before the coming edge is queued; the model then applies that edge.
   task automatic cyc(input logic r, input logic w, input int a,
                      input logic [15:0] d, input logic chk);
      exp_t e;
      @(negedge clk);
      reset       = r;
      bus.write   = w;
      bus.address = address_t'(a[2:0]);
      bus.data_in = d;
      chk_en      = chk;
      if (chk) begin
         e.addr = a[2:0];
         e.exp  = model[a];
         e.tag  = cur_tag;
         sb_q.push_back(e);
      end
      if (r) begin
         for (int k = 0; k < 8; k++) model[k] = rst_tab[k];
      end else if (w) begin
         model[a] = d;
      end
   endtask

   task automatic rd(input int a);
      cyc(1'b0, 1'b0, a, 16'(a * 16'h0101 + 16'h0F0F), 1'b1);
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      cyc(1'b0, 1'b1, a, d, 1'b0);
   endtask

   // Monitor: samples well after the negedge drive, well before the posedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_empty: read with no expected entry");
            end else begin
               e = sb_q.pop_front();
               if (bus.data_out !== e.exp) begin
                  failures++;
                  $display("FAIL %s addr=%0d: got %h expected %h",
                           e.tag, e.addr, bus.data_out, e.exp);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int perm [8];
      int t, j, a;
      logic r, w, c;
      logic [15:0] d;

      rst_tab[0] = 16'hFFFF; rst_tab[1] = 16'h0000;
      rst_tab[2] = 16'h0000; rst_tab[3] = 16'h0000;
      rst_tab[4] = 16'hABCD; rst_tab[5] = 16'h0000;
      rst_tab[6] = 16'h0000; rst_tab[7] = 16'h0001;
      for (int k = 0; k < 8; k++) model[k] = 16'hxxxx;

      reset = 1'b1; bus.write = 1'b0; chk_en = 1'b0;
      bus.address = adc0_reg; bus.data_in = 16'h0000;

      // First reset edge: contents undefined before it, so no check.
      cur_tag = "reset_init";
      cyc(1'b1, 1'b0, 0, 16'h0, 1'b0);

      // Reset readback while reset held.
      cur_tag = "reset_sweep";
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, i, 16'h0, 1'b1);

      // Write distinct values, read back in shuffled order.
      cur_tag = "wr_readback";
      for (int i = 0; i < 8; i++) wr(i, 16'(16'h1111 * (i + 1)));
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 8; i++) rd(perm[i]);

      // Reset beats a concurrent write.
      cur_tag = "reset_priority";
      cyc(1'b1, 1'b1, 6, 16'h5A5A, 1'b0);
      rd(6);
      rd(4);

      // Hold without write.
      cur_tag = "hold";
      wr(4, 16'h1234);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4, 16'hFFFF, 1'b1);
      rd(4);

      // Reset after writes.
      cur_tag = "reset_after_wr";
      for (int i = 0; i < 8; i++) wr(i, 16'hBEEF);
      rd(7);
      cyc(1'b1, 1'b0, 0, 16'h0, 1'b0);
      for (int i = 0; i < 8; i++) rd(i);

      // Back-to-back overwrite; the write cycle itself shows the old value.
      cur_tag = "overwrite";
      wr(7, 16'h00AA);
      cyc(1'b0, 1'b1, 7, 16'h0055, 1'b1);
      rd(7);

      // Randomized traffic, every cycle checked.
      cur_tag = "random";
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(39, 0) == 0);
         w = $urandom_range(1, 0) == 1;
         a = int'($urandom_range(7, 0));
         d = 16'($urandom);
         c = 1'b1;
         cyc(r, w, a, d, c);
      end

      cur_tag = "final";
      for (int i = 0; i < 8; i++) rd(i);

      @(negedge clk);
      chk_en = 1'b0;
      bus.write = 1'b0;
      @(negedge clk);
      #3;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/config_reg.md
# config_reg

Register bank of eight 16-bit configuration/status registers with a single write port and a combinational read port. Each register is selected by an enumerated address and has its own reset value. It sits between a host-side register access interface and the analog/digital front-end control logic, which consume the stored values.

## Interface
Parameters: none. Widths and reset values are fixed constants from the shared package.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- write  input  1  write enable; 1 = write `data_in` to the addressed register on the next rising edge.
- data_in  input  16  write data.
- address  input  address_t (3 bits)  register select.
- data_out  output  16  contents of the register selected by `address`.

## Operation
Address map (address_t encoding, reset value):
- adc0_reg = 0, 16'hFFFF
- adc1_reg = 1, 16'h0000
- temp_sensor0_reg = 2, 16'h0000
- temp_sensor1_reg = 3, 16'h0000
- analog_test = 4, 16'hABCD
- digital_test = 5, 16'h0000
- amp_gain = 6, 16'h0000
- digital_config = 7, 16'h0001

Register updates:
- On a rising edge with reset=1, every register loads its reset value.
- On a rising edge with reset=0 and write=1, only the register at `address` loads `data_in`. All other registers hold.
- On a rising edge with reset=0 and write=0, all registers hold.

Read path:
- data_out = reg[address]. It is combinational and is valid regardless of `write`.
- During a write, data_out shows the old value until the clock edge, then the new value.

Other rules:
- Registers are full 16-bit read/write. There are no read-only or reserved bits.
- Writes store `data_in` as given; there is no masking.

## Timing
- Write latency: one clock. The value written at edge N is visible on data_out immediately after edge N.
- Read latency: zero cycles. data_out follows `address` combinationally.
- Reset is synchronous. Registers take reset values at the first rising edge where reset=1. Before that edge, the contents are undefined.
- reset=1 together with write=1: reset wins and the write is discarded.
- Reset asserted mid-sequence: previously written data is lost at that edge. While reset is held, data_out reads the reset value of whichever address is applied.
- Back-to-back writes to the same address on consecutive cycles: the last write wins.
- Address and data change at the negedge in the bench; both must be stable before the rising edge.

## Structure
- Shared package `config_reg_pkg` contains:
  - `typedef enum logic [2:0] address_t`, with the eight names in the encoding order above;
  - one 16-bit localparam per register reset value;
  - a `NUM_REGS = 8` constant.
- Natural sub-module: `config_reg_cell`, a 16-bit register with synchronous reset to a parameterised `RESET_VAL` and a load enable.
  - config_reg instantiates eight cells.
  - Each cell's enable is `write && (address == its index)`.
  - The read side is an 8:1 mux.

## Test plan
- Reset readback: hold reset=1 and sweep addresses 0..7, one per cycle. data_out must read FFFF, 0000, 0000, 0000, ABCD, 0000, 0000, 0001.
- Write/readback: after reset, write distinct values to all 8 addresses (e.g. 16'h1111·(i+1)), then read in shuffled order. Each address must return exactly its written value; no cross-address corruption.
- Reset priority: with reset=1 and write=1, address=amp_gain, data_in=16'h5A5A. Afterwards amp_gain must read 16'h0000.
- Hold without write: write analog_test=16'h1234, then drive write=0 with data_in=16'hFFFF for 3 cycles. analog_test must still read 16'h1234.
- Reset after writes: write 16'hBEEF to all registers, then assert reset for one edge. All registers must return to their reset values; digital_config must read 16'h0001.
- Overwrite: write digital_config=16'h00AA, then 16'h0055 on the next cycle. The final read must return 16'h0055.
